// File: rtl/uart_pkg.sv
// Shared UART encodings: parity-mode and data-length codes, plus the
// masked XOR reduction used by the transmit parity generator.
package uart_pkg;

    localparam int MAX_DATA_LEN = 8;

    localparam logic [1:0] PARITY_EVEN  = 2'b00;
    localparam logic [1:0] PARITY_ODD   = 2'b01;
    localparam logic [1:0] PARITY_MARK  = 2'b10;
    localparam logic [1:0] PARITY_SPACE = 2'b11;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    function automatic int len_to_bits(input logic [1:0] data_len);
        return 5 + int'(data_len);
    endfunction

    // Bits at or above active_len are treated as zero, so they drop out of the XOR.
    function automatic logic masked_xor(input logic [MAX_DATA_LEN-1:0] data,
                                        input int active_len);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_DATA_LEN; i++) begin
            if (i < active_len) begin
                r = r ^ data[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_parity_gen.sv
// Transmit parity generator: masks the data word to the selected length,
// reduces it to a parity bit per the selected mode, and registers the result.
module tx_parity_gen
    import uart_pkg::*;
#(
    parameter int   DATA_WIDTH   = 8,
    parameter logic RESET_PARITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_data,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            parity_mode,
    input  logic [1:0]            data_len,
    output logic                  parity_bit,
    output logic                  parity_valid
);

    logic [MAX_DATA_LEN-1:0] data_ext;
    int                      active_len;
    logic                    reduced;
    logic                    next_parity;

    // Narrow words are zero-extended so the absent upper bits never contribute.
    generate
        if (DATA_WIDTH >= MAX_DATA_LEN) begin : g_wide
            assign data_ext = tx_data[MAX_DATA_LEN-1:0];
        end else begin : g_narrow
            assign data_ext = {{(MAX_DATA_LEN-DATA_WIDTH){1'b0}}, tx_data};
        end
    endgenerate

    always_comb begin
        active_len = len_to_bits(data_len);
        if (active_len > DATA_WIDTH) begin
            active_len = DATA_WIDTH;
        end
        reduced = masked_xor(data_ext, active_len);
        unique case (parity_mode)
            PARITY_EVEN:  next_parity = reduced;
            PARITY_ODD:   next_parity = ~reduced;
            PARITY_MARK:  next_parity = 1'b1;
            PARITY_SPACE: next_parity = 1'b0;
            default:      next_parity = reduced;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit   <= RESET_PARITY;
            parity_valid <= 1'b0;
        end else begin
            parity_valid <= load_data;
            if (load_data) begin
                parity_bit <= next_parity;
            end
        end
    end

endmodule

// File: tb/tb_tx_parity_gen.sv
// Self-checking bench for tx_parity_gen: directed cases, hold, async reset and
// randomized traffic against a ones-count reference model.
module tb_tx_parity_gen;

    logic       clk;
    logic       rst_n;
    logic       load_data;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic [1:0] data_len;
    logic       parity_bit;
    logic       parity_valid;

    int checks;
    int passed;

    tx_parity_gen #(.DATA_WIDTH(8), .RESET_PARITY(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_data    (load_data),
        .tx_data      (tx_data),
        .parity_mode  (parity_mode),
        .data_len     (data_len),
        .parity_bit   (parity_bit),
        .parity_valid (parity_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count the ones in the low (5+len) bits and derive parity from that count.
    function automatic logic model_parity(input logic [7:0] d, input logic [1:0] mode,
                                          input logic [1:0] len);
        int         n;
        int         ones;
        logic [15:0] mask;
        n    = 5 + int'(len);
        mask = (16'd1 << n) - 16'd1;
        ones = $countones(d & mask[7:0]);
        case (mode)
            2'b00:   return (ones % 2) == 1;
            2'b01:   return (ones % 2) == 0;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic ld, input logic [7:0] d, input logic [1:0] mode,
                         input logic [1:0] len);
        load_data   = ld;
        tx_data     = d;
        parity_mode = mode;
        data_len    = len;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (parity_bit !== 1'b0 || parity_valid !== 1'b0)
            $display("[TB] FAIL reset_async: parity_bit=%0b valid=%0b expected 0/0", parity_bit, parity_valid);
        else passed++;
        drive(1'b1, 8'hFF, 2'b01, 2'b11);
        @(negedge clk);
        checks++;
        if (parity_bit !== 1'b0 || parity_valid !== 1'b0)
            $display("[TB] FAIL reset_hold: parity_bit=%0b valid=%0b expected 0/0", parity_bit, parity_valid);
        else passed++;
        drive(1'b0, 8'h00, 2'b00, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] d    [8] = '{8'b10110101, 8'b00110101, 8'b00110101, 8'b10110101,
                                 8'b10110101, 8'hFF, 8'h00, 8'hFF};
        logic [1:0] m    [8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
        logic [1:0] l    [8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11};
        logic       exp  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, d[i], m[i], l[i]);
            @(negedge clk);
            checks++;
            if (parity_bit !== exp[i] || parity_valid !== 1'b1)
                $display("[TB] FAIL directed_%0d: parity_bit=%0b valid=%0b expected %0b/1",
                         i, parity_bit, parity_valid, exp[i]);
            else passed++;
        end
        drive(1'b1, 8'h00, 2'b11, 2'b00);
        @(negedge clk);
        checks++;
        if (parity_bit !== 1'b0)
            $display("[TB] FAIL space_zero: parity_bit=%0b expected 0", parity_bit);
        else passed++;
    endtask

    task automatic test_hold();
        drive(1'b1, 8'b10110101, 2'b00, 2'b11);
        @(negedge clk);
        checks++;
        if (parity_bit !== 1'b1 || parity_valid !== 1'b1)
            $display("[TB] FAIL hold_load: parity_bit=%0b valid=%0b expected 1/1", parity_bit, parity_valid);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            @(negedge clk);
            checks++;
            if (parity_bit !== 1'b1 || parity_valid !== 1'b0)
                $display("[TB] FAIL hold_cycle_%0d: parity_bit=%0b valid=%0b expected 1/0",
                         i, parity_bit, parity_valid);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [1:0] m;
        logic [1:0] l;
        logic       exp;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            m = 2'(i % 2);
            l = 2'($urandom_range(0, 3));
            exp = model_parity(d, m, l);
            drive(1'b1, d, m, l);
            @(negedge clk);
            checks++;
            if (parity_bit !== exp || parity_valid !== 1'b1)
                $display("[TB] FAIL b2b_%0d: parity_bit=%0b valid=%0b expected %0b/1",
                         i, parity_bit, parity_valid, exp);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic       exp_parity;
        logic       ld;
        logic [7:0] d;
        logic [1:0] m;
        logic [1:0] l;
        exp_parity = parity_bit;
        drive(1'b1, 8'h5A, 2'b00, 2'b11);
        exp_parity = model_parity(8'h5A, 2'b00, 2'b11);
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            ld = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            m  = 2'($urandom_range(0, 3));
            l  = 2'($urandom_range(0, 3));
            if (ld) exp_parity = model_parity(d, m, l);
            drive(ld, d, m, l);
            @(negedge clk);
            checks++;
            if (parity_bit !== exp_parity || parity_valid !== ld)
                $display("[TB] FAIL random_%0d: parity_bit=%0b valid=%0b expected %0b/%0b",
                         i, parity_bit, parity_valid, exp_parity, ld);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'b10110101, 2'b00, 2'b11);
        @(negedge clk);
        checks++;
        if (parity_bit !== 1'b1)
            $display("[TB] FAIL arst_preload: parity_bit=%0b expected 1", parity_bit);
        else passed++;
        drive(1'b1, 8'b00000001, 2'b00, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (parity_bit !== 1'b0 || parity_valid !== 1'b0)
            $display("[TB] FAIL arst_immediate: parity_bit=%0b valid=%0b expected 0/0", parity_bit, parity_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (parity_bit !== 1'b0 || parity_valid !== 1'b0)
            $display("[TB] FAIL arst_override_load: parity_bit=%0b valid=%0b expected 0/0", parity_bit, parity_valid);
        else passed++;
        rst_n = 1'b1;
        drive(1'b1, 8'b10110101, 2'b00, 2'b11);
        @(negedge clk);
        checks++;
        if (parity_bit !== 1'b1 || parity_valid !== 1'b1)
            $display("[TB] FAIL arst_first_capture: parity_bit=%0b valid=%0b expected 1/1", parity_bit, parity_valid);
        else passed++;
        drive(1'b0, 8'h00, 2'b00, 2'b11);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 2'b11);
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
